// File: rtl/rng_pkg.sv
// -----------------------------------------------------------------------------
// rng_pkg
// Shared definitions for the PCG random-number pipeline: word width, word
// type, the default LCG multiplier/increment used by the generator stage, and
// the multiply-shift range reduction used by the consumer stage.
// -----------------------------------------------------------------------------
package rng_pkg;

  localparam int unsigned RNG_W = 32;

  typedef logic [RNG_W-1:0] rng_word_t;

  // 64-bit PCG state-update constants (generator stage)
  localparam logic [63:0] RNG_DEFAULT_MULT = 64'h5851_F42D_4C95_7F2D;
  localparam logic [63:0] RNG_DEFAULT_INC  = 64'h1405_7B7E_F767_814F;

  // Reduce word into [0, bound) via the upper half of the full 64-bit product.
  // A bound of zero means "no reduction": the word passes through unchanged.
  function automatic rng_word_t rng_reduce(input rng_word_t word, input rng_word_t bound);
    logic [2*RNG_W-1:0] prod;
    rng_word_t          res;
    prod = {{RNG_W{1'b0}}, word} * {{RNG_W{1'b0}}, bound};
    if (bound == {RNG_W{1'b0}}) begin
      res = word;
    end else begin
      res = rng_word_t'(prod >> RNG_W);
    end
    return res;
  endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// -----------------------------------------------------------------------------
// rng_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on rd_data_o; level_o counts stored entries (0..DEPTH).
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (pointers/level only)
//   flush_i    synchronous empty; wins over write and read
//   wr_en_i    write wr_data_i this cycle (caller guarantees space)
//   wr_data_i  data to store
//   rd_en_i    pop the head this cycle (ignored when empty)
//   rd_data_o  head entry
//   level_o    number of stored entries
// -----------------------------------------------------------------------------
module rng_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_s;
  logic             rd_s;

  assign wr_s      = wr_en_i & ~flush_i;
  assign rd_s      = rd_en_i & ~flush_i & (level_q != {LW{1'b0}});
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Next-state for pointers and level; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, rd_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/rng_range_fifo.sv
// -----------------------------------------------------------------------------
// rng_range_fifo
// Consumer stage for PCG output words: reduces each accepted word into
// [0, bound) (raw pass-through when bound is 0), buffers results in a FWFT
// FIFO, and counts words refused while full.
//   clk         clock
//   rst         asynchronous active-low reset
//   clear       synchronous flush of pipe, FIFO and drop counter
//   in_valid    generator word offered     in_ready  stage accepts this cycle
//   in_data     generator word             bound     range limit (0 = raw)
//   out_valid   FIFO head valid            out_ready consumer takes head
//   out_data    FIFO head                  level     FIFO entries (no pipe)
//   drop_count  saturating count of refused offers
// -----------------------------------------------------------------------------
module rng_range_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  rng_word_t              in_data,
  input  rng_word_t              bound,
  output logic                   out_valid,
  input  logic                   out_ready,
  output rng_word_t              out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic              pipe_valid_q, pipe_valid_d;
  rng_word_t         pipe_data_q, pipe_data_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [LW:0]       occ_s;
  logic              accept_s;
  logic              fifo_rd_s;

  // Readiness counts the in-flight pipe word so an accepted word always has a
  // FIFO slot; it is built from registered state only (no path from out_ready).
  assign occ_s      = {1'b0, level} + {{LW{1'b0}}, pipe_valid_q};
  assign in_ready   = (occ_s < (LW+1)'(DEPTH));
  assign accept_s   = in_valid & in_ready;
  assign out_valid  = (level != {LW{1'b0}});
  assign fifo_rd_s  = out_valid & out_ready;
  assign drop_count = drop_q;

  rng_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RNG_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .flush_i   (clear),
    .wr_en_i   (pipe_valid_q),
    .wr_data_i (pipe_data_q),
    .rd_en_i   (fifo_rd_s),
    .rd_data_o (out_data),
    .level_o   (level)
  );

  // Pipe and drop-counter next state; clear discards accepted words.
  always_comb begin
    pipe_valid_d = 1'b0;
    pipe_data_d  = pipe_data_q;
    drop_d       = drop_q;
    if (clear) begin
      pipe_valid_d = 1'b0;
      drop_d       = {DROP_W{1'b0}};
    end else begin
      pipe_valid_d = accept_s;
      if (accept_s) begin
        pipe_data_d = rng_reduce(in_data, bound);
      end else begin
        pipe_data_d = pipe_data_q;
      end
      if (in_valid && !in_ready && (drop_q != {DROP_W{1'b1}})) begin
        drop_d = drop_q + DROP_W'(1);
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Pipe register and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= {RNG_W{1'b0}};
      drop_q       <= {DROP_W{1'b0}};
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_rng_range_fifo.sv
// Directed testbench for rng_range_fifo (DEPTH=8, DROP_W=16).
module tb_rng_range_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] bound;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  level;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  rng_range_fifo #(.DEPTH(8), .DROP_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bound      (bound),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'h0; bound = 32'h0;
    step(); step();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0h expected 0", drop_count); end
    rst = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_passthrough();
    bound = 32'h0; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_latency1: out_valid got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pass_data: got %08h expected deadbeef", out_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL pass_level: got %0d expected 1", level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: level %0d valid %b expected 0 0", level, out_valid); end
  endtask

  task automatic test_reduce();
    logic [31:0] vd [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    vd[0] = 32'hFFFFFFFF; vb[0] = 32'd6;          ve[0] = 32'd5;
    vd[1] = 32'h80000000; vb[1] = 32'd6;          ve[1] = 32'd3;
    vd[2] = 32'h00000000; vb[2] = 32'd6;          ve[2] = 32'd0;
    vd[3] = 32'h40000000; vb[3] = 32'd1000;       ve[3] = 32'd250;
    vd[4] = 32'h12345678; vb[4] = 32'd0;          ve[4] = 32'h12345678;
    vd[5] = 32'hFFFFFFFF; vb[5] = 32'hFFFFFFFF;   ve[5] = 32'hFFFFFFFE;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = vd[i]; bound = vb[i];
      step();
    end
    in_valid = 1'b0;
    step(); step();
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL reduce_level: got %0d expected 6", level); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, ve[i]}) begin
        errors++; $display("FAIL reduce_word%0d: got valid %b data %08h expected 1 %08h", i, out_valid, out_data, ve[i]);
      end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reduce_empty: got %0d expected 0", level); end
  endtask

  task automatic test_fill_drop();
    int accepts;
    accepts = 0;
    bound = 32'h0; out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!in_ready) break;
      in_data = accepts;
      step();
      accepts++;
    end
    checks++; if (accepts !== 8) begin errors++; $display("FAIL fill_accepts: got %0d expected 8", accepts); end
    step();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level: got %0d expected 8", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    step(); step();
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL fill_drops: got %0d expected 3", drop_count); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_no_comb_path: in_ready got %b expected 0", in_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL fill_pop_level: got %0d expected 7", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %b expected 1", in_ready); end
    for (int k = 1; k < 8; k++) begin
      checks++;
      if (out_data !== k) begin errors++; $display("FAIL fill_order%0d: got %08h expected %08h", k, out_data, k); end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL fill_drained: got %0d expected 0", level); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_in;
    logic [31:0] next_out;
    int pops;
    next_in = 32'd100; next_out = 32'd100; pops = 0;
    bound = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = next_in;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", c, in_ready); end
      if (c >= 2) begin
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL b2b_level%0d: got %0d expected 1", c, level); end
        checks++;
        if ({out_valid, out_data} !== {1'b1, next_out}) begin
          errors++; $display("FAIL b2b_data%0d: got valid %b data %08h expected 1 %08h", c, out_valid, out_data, next_out);
        end
        next_out++;
        pops++;
      end
      next_in++;
      step();
    end
    checks++; if (pops !== 18) begin errors++; $display("FAIL b2b_pops: got %0d expected 18", pops); end
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL b2b_no_drops: got %0d expected 3", drop_count); end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", level); end
  endtask

  task automatic test_saturate_clear();
    bound = 32'h0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    for (int c = 0; c < 70000; c++) step();
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %04h expected ffff", drop_count); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL sat_level: got %0d expected 8", level); end
    step(); step(); step();
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %04h expected ffff", drop_count); end
    // free one slot, then park a word in the pipe
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hCAFE0001;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL clear_drop: got %04h expected 0", drop_count); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL clear_level: got %0d expected 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b expected 1", in_ready); end
    step(); step();
    checks++; if (level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear_pipe_discard: level %0d valid %b expected 0 0", level, out_valid); end
    // word accepted while clear is high is discarded
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h5555AAAA;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_ready_during: got %b expected 1", in_ready); end
    step();
    clear = 1'b0; in_valid = 1'b0;
    step(); step();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL clear_accept_discard: got %0d expected 0", level); end
  endtask

  task automatic test_async_reset();
    int accepts;
    accepts = 0;
    bound = 32'h0; out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!in_ready) break;
      in_data = accepts;
      step();
      accepts++;
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL arst_pre_level: got %0d expected 5", level); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL arst_pre_drop: got %0d expected 1", drop_count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL arst_level: got %0d expected 0", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL arst_drop: got %0d expected 0", drop_count); end
    step();
    rst = 1'b1;
    in_valid = 1'b1; bound = 32'd6; in_data = 32'h80000000;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if ({out_valid, out_data, level} !== {1'b1, 32'd3, 4'd1}) begin
      errors++; $display("FAIL arst_resume: got valid %b data %08h level %0d expected 1 00000003 1", out_valid, out_data, level);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_reduce();
    test_fill_drop();
    test_back_to_back();
    test_saturate_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
